start_fifo_srl_ctrl: RTL
========================

// Module: start_fifo_srl_ctrl
//
// PURPOSE
// - Handshake and address controller for an SRL-style start-token FIFO between two dataflow stages
//   (e.g. a tile loader and one PE_i4xi4 instance).
// - Keeps its own SRL storage array: shift-in on accepted write, read at a variable tap address.
// - Tracks occupancy and drives full/empty handshakes so the producer and consumer can stall safely.
//
// PARAMETERS
// - DATA_WIDTH  1  width of each stored token
// - ADDR_WIDTH  1  tap address width; requires 2**ADDR_WIDTH >= DEPTH
// - DEPTH       2  number of SRL entries (>= 2)
//
// PORTS
// - ap_clk      in   1           single clock; all state updates on rising edge
// - ap_rst_n    in   1           asynchronous active-low reset
// - if_write    in   1           producer write strobe; accepted only when if_full_n=1
// - if_din      in   DATA_WIDTH  write data
// - if_full_n   out  1           1 = at least one free entry
// - if_read     in   1           consumer read strobe; accepted only when if_empty_n=1
// - if_dout     out  DATA_WIDTH  oldest token, valid while if_empty_n=1
// - if_empty_n  out  1           1 = at least one valid entry
//
// BEHAVIOUR
// - Accept rules: push = if_write & if_full_n; pop = if_read & if_empty_n.
// - Storage: on push, entry[i+1] <= entry[i] for all i, entry[0] <= if_din. Storage is not reset.
// - Tap: if_dout = entry[tap]; tap always indexes the oldest valid token.
// - State machine (registered), with cnt = number of valid entries:
//   - S_EMPTY: cnt=0, tap=0, if_empty_n=0, if_full_n=1.
//   - S_PART: 0 < cnt < DEPTH, if_empty_n=1, if_full_n=1.
//   - S_FULL: cnt=DEPTH, tap=DEPTH-1, if_empty_n=1, if_full_n=0.
// - Transitions:
//   - S_EMPTY: push -> S_PART (tap stays 0). A read is ignored.
//   - S_PART, push only: tap+1; move to S_FULL when the new cnt = DEPTH.
//   - S_PART, pop only: tap-1; move to S_EMPTY when the old cnt = 1 (tap held at 0, no underflow).
//   - S_PART, push and pop together: tap and cnt unchanged, state unchanged.
//   - S_FULL: pop -> S_PART with tap=DEPTH-2. A write is ignored even when a pop happens in the
//     same cycle; that write must be retried.
// - Latency:
//   - Write to read: a token pushed in cycle N drives if_empty_n=1 and if_dout in cycle N+1.
//   - Pop to free space: if_full_n rises the cycle after the pop.
// - Flags come straight from registered state; no combinational path from if_write or if_read to
//   if_full_n or if_empty_n.
// - Reset values (async assert, sync release): state=S_EMPTY, tap=0, cnt=0, if_empty_n=0,
//   if_full_n=1. if_dout is undefined until the first push.
// - Reset mid-operation: all queued tokens are discarded; stale data stays in the SRL but is never
//   presented as valid.
// - No overflow and no underflow is possible; ignored strobes leave all state unchanged.
//
// CONFIGURATION
// - Macro START_FIFO_OCC_EN.
// - Defined: adds output if_num_data_valid [ADDR_WIDTH:0] = cnt, registered, reset 0, updated on the
//   same edge as the flags. Also adds output if_fifo_cap [ADDR_WIDTH:0] = DEPTH (constant).
// - Undefined: neither port exists; cnt logic may be reduced to the tap plus the state encoding.
//   Handshake behaviour is identical either way.
//
// TESTING
// - Reset: hold ap_rst_n=0, then release -> if_empty_n=0, if_full_n=1; if_read pulses have no
//   effect.
// - Fill and drain (DEPTH=4): write 0xA,0xB,0xC,0xD on consecutive cycles.
//   -> if_full_n=0 after the 4th write.
//   -> reads return A,B,C,D in order; if_empty_n=0 after the 4th read.
// - Simultaneous push/pop at cnt=2 for 10 cycles with a ramp 1..10
//   -> cnt stays 2; read sequence is in-order, with no loss or duplication.
// - Write when full plus a concurrent read -> the read is accepted, the write is dropped; next cycle
//   if_full_n=1 and cnt=DEPTH-1.
// - Assert ap_rst_n asynchronously (mid-clock) with 3 tokens queued -> flags return to reset values
//   immediately; after release the first new write is the first token read.
// - With START_FIFO_OCC_EN: random push/pop for 1000 cycles vs a reference queue model
//   -> if_num_data_valid matches the model every cycle and never exceeds DEPTH.

Source files
------------

// File: rtl/start_fifo_srl_ctrl_if.sv
// Handshake bundle between the start-token FIFO and its producer/consumer.
// The occupancy/capacity signals exist only when START_FIFO_OCC_EN is defined.
interface start_fifo_srl_ctrl_if #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1
);
    logic                  if_write;
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_full_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_empty_n;
`ifdef START_FIFO_OCC_EN
    logic [ADDR_WIDTH:0]   if_num_data_valid;
    logic [ADDR_WIDTH:0]   if_fifo_cap;

    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
    );
    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid, if_fifo_cap
    );
`else
    modport master (
        output if_write, if_din, if_read,
        input  if_full_n, if_dout, if_empty_n
    );
    modport slave (
        input  if_write, if_din, if_read,
        output if_full_n, if_dout, if_empty_n
    );
`endif
endinterface

// File: rtl/start_fifo_srl_ctrl.sv
// SRL-style start-token FIFO: shift-in storage, tap read of the oldest token, registered flags.
// Define START_FIFO_OCC_EN to add the if_num_data_valid / if_fifo_cap outputs.
module start_fifo_srl_ctrl #(
    parameter int DATA_WIDTH = 1,
    parameter int ADDR_WIDTH = 1,
    parameter int DEPTH      = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    start_fifo_srl_ctrl_if.slave   fifo
);
    localparam logic [ADDR_WIDTH-1:0] TAP_PENULT = ADDR_WIDTH'(DEPTH - 2);
    localparam logic [ADDR_WIDTH-1:0] TAP_LAST   = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {S_EMPTY, S_PART, S_FULL} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   tap_reg, tap_next;
    logic                    full_n, empty_n;
    logic                    push, pop;
    logic [DATA_WIDTH-1:0]   entry [DEPTH];

    // Flags decode the registered state only, so strobes never reach them combinationally.
    assign full_n  = (state_reg != S_FULL);
    assign empty_n = (state_reg != S_EMPTY);
    assign push    = fifo.if_write & full_n;
    assign pop     = fifo.if_read & empty_n;

    assign fifo.if_full_n  = full_n;
    assign fifo.if_empty_n = empty_n;
    assign fifo.if_dout    = entry[tap_reg];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg <= S_EMPTY;
            tap_reg   <= '0;
        end else begin
            state_reg <= state_next;
            tap_reg   <= tap_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tap_next   = tap_reg;
        case (state_reg)
            S_EMPTY: begin
                tap_next = '0;
                if (push) state_next = S_PART;
            end
            S_PART: begin
                if (push && !pop) begin
                    tap_next = tap_reg + 1'b1;
                    if (tap_reg == TAP_PENULT) state_next = S_FULL;
                end else if (pop && !push) begin
                    if (tap_reg == '0) state_next = S_EMPTY;
                    else               tap_next   = tap_reg - 1'b1;
                end
            end
            S_FULL: begin
                tap_next = TAP_LAST;
                // A write in the same cycle is dropped: full_n was low when it was presented.
                if (pop) begin
                    state_next = S_PART;
                    tap_next   = TAP_PENULT;
                end
            end
            default: begin
                state_next = S_EMPTY;
                tap_next   = '0;
            end
        endcase
    end

    // Shift register storage, intentionally not reset; validity is tracked by the state alone.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_srl
        logic [DATA_WIDTH-1:0] entry_reg;
        if (gi == 0) begin : g_head
            always_ff @(posedge ap_clk) begin
                if (push) entry_reg <= fifo.if_din;
            end
        end else begin : g_tail
            always_ff @(posedge ap_clk) begin
                if (push) entry_reg <= entry[gi-1];
            end
        end
        assign entry[gi] = entry_reg;
    end

`ifdef START_FIFO_OCC_EN
    logic [ADDR_WIDTH:0] cnt_reg, cnt_next;

    // In every non-empty state the count is one more than the tap.
    always_comb begin
        cnt_next = '0;
        if (state_next != S_EMPTY) cnt_next = {1'b0, tap_next} + (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) cnt_reg <= '0;
        else           cnt_reg <= cnt_next;
    end

    assign fifo.if_num_data_valid = cnt_reg;
    assign fifo.if_fifo_cap       = (ADDR_WIDTH+1)'(DEPTH);
`endif

endmodule
